// File: rtl/int_alu_pkg.sv
// Shared constants and types for the integer ALU sequencer: bus codes, opcodes,
// response error codes and the command FSM states.
package int_alu_pkg;

    localparam logic [3:0] ALU_EN   = 4'h5;

    localparam logic [7:0] OP_ADD   = 8'h10;
    localparam logic [7:0] OP_SUB   = 8'h11;
    localparam logic [7:0] OP_MUL   = 8'h12;
    localparam logic [7:0] OP_DIV   = 8'h13;

    localparam logic [3:0] SEL_A    = 4'h0;
    localparam logic [3:0] SEL_B    = 4'h1;
    localparam logic [3:0] SEL_EXEC = 4'h2;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_OP   = 2'b01,
        ERR_DIV0 = 2'b10
    } resp_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_CAPT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/int_alu_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// returned both as a one-hot grant and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_alu_sequencer.sv
// Round-robin front end for the integer ALU: grants one requester at a time,
// walks write-A / write-B / read on the ALU bus and returns the result with its ID.
module int_alu_sequencer #(
    parameter int         NUM_REQ = 2,
    parameter int         DATA_W  = 16,
    parameter int         BUS_W   = 256,
    parameter logic [3:0] ALU_EN  = int_alu_pkg::ALU_EN
) (
    input  logic                       Clk,
    input  logic                       nReset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [8*NUM_REQ-1:0]       req_op,
    input  logic [DATA_W*NUM_REQ-1:0]  req_a,
    input  logic [DATA_W*NUM_REQ-1:0]  req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]          resp_data,
    output logic [1:0]                 resp_err,
    output logic [15:0]                address,
    output logic                       nWrite,
    output logic                       nRead,
    output logic [BUS_W-1:0]           ExeDataOut,
    input  logic [BUS_W-1:0]           IntDataOut
);

    import int_alu_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [7:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    state_e             state, state_next;
    cmd_t               cmd;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    int                 sel;
    logic               op_legal;
    logic               div0;
    logic [15:0]        address_d;
    logic               nwrite_d;
    logic               nread_d;
    logic [BUS_W-1:0]   exe_d;
    logic               unused_int;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel        = int'(gnt_idx);
    assign op_legal   = cmd.op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    assign div0       = (cmd.op == OP_DIV) && (cmd.b == '0);
    assign unused_int = ^IntDataOut[BUS_W-1:DATA_W];

    always_ff @(posedge Clk) begin
        if (!nReset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (gnt_any) state_next = ST_GRANT;
            ST_GRANT:  state_next = (!op_legal || div0) ? ST_RESP : ST_LOAD_A;
            ST_LOAD_A: state_next = ST_LOAD_B;
            ST_LOAD_B: state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_CAPT;
            ST_CAPT:   state_next = ST_RESP;
            ST_RESP:   if (resp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Bus drive is decoded from the next state so the registered bus lines up with the state.
    always_comb begin
        address_d = '0;
        nwrite_d  = 1'b1;
        nread_d   = 1'b1;
        exe_d     = '0;
        case (state_next)
            ST_LOAD_A: begin
                address_d = {ALU_EN, SEL_A, cmd.op};
                nwrite_d  = 1'b0;
                exe_d     = BUS_W'(cmd.a);
            end
            ST_LOAD_B: begin
                address_d = {ALU_EN, SEL_B, cmd.op};
                nwrite_d  = 1'b0;
                exe_d     = BUS_W'(cmd.b);
            end
            ST_EXEC: begin
                address_d = {ALU_EN, SEL_EXEC, cmd.op};
                nread_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            rr_ptr     <= '0;
            cmd        <= '0;
            req_ready  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= ERR_OK;
            address    <= '0;
            nWrite     <= 1'b1;
            nRead      <= 1'b1;
            ExeDataOut <= '0;
        end else begin
            address    <= address_d;
            nWrite     <= nwrite_d;
            nRead      <= nread_d;
            ExeDataOut <= exe_d;
            req_ready  <= '0;
            if (state == ST_IDLE && gnt_any) begin
                req_ready <= gnt;
                cmd.id    <= gnt_idx;
                cmd.op    <= req_op[8*sel +: 8];
                cmd.a     <= req_a[DATA_W*sel +: DATA_W];
                cmd.b     <= req_b[DATA_W*sel +: DATA_W];
                rr_ptr    <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state == ST_GRANT && !op_legal) begin
                resp_valid <= 1'b1;
                resp_id    <= cmd.id;
                resp_data  <= '0;
                resp_err   <= ERR_OP;
            end else if (state == ST_GRANT && div0) begin
                resp_valid <= 1'b1;
                resp_id    <= cmd.id;
                resp_data  <= '1;
                resp_err   <= ERR_DIV0;
            end else if (state == ST_CAPT) begin
                resp_valid <= 1'b1;
                resp_id    <= cmd.id;
                resp_data  <= IntDataOut[DATA_W-1:0];
                resp_err   <= ERR_OK;
            end else if (state == ST_RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_int_alu_sequencer.sv
// Bench for int_alu_sequencer: behavioural ALU on the bus, directed plus random
// commands checked against a spec-level result model.
module tb_int_alu_sequencer;

    localparam int NR = 2;

    logic           Clk = 1'b0;
    logic           nReset = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_ready;
    logic [8*NR-1:0]  req_op = '0;
    logic [16*NR-1:0] req_a = '0;
    logic [16*NR-1:0] req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [0:0]     resp_id;
    logic [15:0]    resp_data;
    logic [1:0]     resp_err;
    logic [15:0]    address;
    logic           nWrite, nRead;
    logic [255:0]   ExeDataOut;
    logic [255:0]   IntDataOut;

    int total = 0;
    int bad = 0;

    int_alu_sequencer #(.NUM_REQ(NR), .DATA_W(16), .BUS_W(256), .ALU_EN(4'h5)) dut (
        .Clk(Clk), .nReset(nReset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .address(address), .nWrite(nWrite), .nRead(nRead),
        .ExeDataOut(ExeDataOut), .IntDataOut(IntDataOut)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            8'h10:   return a + b;
            8'h11:   return a - b;
            8'h12:   return 16'((32'(a) * 32'(b)) & 32'hFFFF);
            8'h13:   return (b == 0) ? 16'hFFFF : a / b;
            default: return 16'h0;
        endcase
    endfunction

    function automatic void ref_model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] d, output logic [1:0] e);
        if (!(op inside {8'h10, 8'h11, 8'h12, 8'h13})) begin d = 16'h0; e = 2'b01; end
        else if (op == 8'h13 && b == 0)               begin d = 16'hFFFF; e = 2'b10; end
        else                                          begin d = alu_fn(op, a, b); e = 2'b00; end
    endfunction

    // Behavioural ALU: result is only presented for the one cycle after the read strobe.
    logic [15:0] alu_a = '0, alu_b = '0, alu_res = '0;
    logic        res_vld = 1'b0;
    always @(posedge Clk) begin
        res_vld <= 1'b0;
        if (address[15:12] == 4'h5) begin
            if (!nWrite && address[11:8] == 4'h0) alu_a <= ExeDataOut[15:0];
            if (!nWrite && address[11:8] == 4'h1) alu_b <= ExeDataOut[15:0];
            if (!nRead && address[11:8] == 4'h2) begin
                alu_res <= alu_fn(address[7:0], alu_a, alu_b);
                res_vld <= 1'b1;
            end
        end
    end
    assign IntDataOut = {240'd0, res_vld ? alu_res : 16'hDEAD};

    typedef struct packed {logic [15:0] addr; logic nw; logic nr; logic [15:0] d;} bus_t;
    bus_t bus_log[$];
    int   bus_act = 0;
    always @(negedge Clk) begin
        if (address != 16'h0 || !nWrite || !nRead || ExeDataOut != '0) begin
            bus_act <= bus_act + 1;
            bus_log.push_back('{address, nWrite, nRead, ExeDataOut[15:0]});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 0);
        chk({tag, "_rvalid"}, 64'(resp_valid), 0);
        chk({tag, "_rid"}, 64'(resp_id), 0);
        chk({tag, "_rdata"}, 64'(resp_data), 0);
        chk({tag, "_rerr"}, 64'(resp_err), 0);
        chk({tag, "_addr"}, 64'(address), 0);
        chk({tag, "_nwr"}, 64'({nWrite, nRead}), 64'b11);
        chk({tag, "_exe0"}, 64'(ExeDataOut == '0), 1);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
    endtask

    task automatic set_cmd(input int id, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[8*id +: 8]  = op;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
    endtask

    // Issue one command from requester id; enters and leaves on a negedge.
    task automatic run_one(input int id, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        int act0;
        logic [15:0] ed;
        logic [1:0]  ee;
        ref_model(op, a, b, ed, ee);
        set_cmd(id, op, a, b);
        req_valid[id] = 1'b1;
        act0 = bus_act;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 40) begin @(negedge Clk); n++; end
        chk("grant_seen", 64'(n < 40), 1);
        if (n >= 40) begin req_valid[id] = 1'b0; return; end
        n = 0;
        do begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                req_valid[id] = 1'b0;
                chk("ready_one_cycle", 64'(req_ready), 0);
            end
        end while (resp_valid !== 1'b1 && n < 40);
        chk("resp_seen", 64'(n < 40), 1);
        if (ee == 2'b00) begin
            chk("latency", 64'(n), 5);
            chk("bus_cycles", 64'(bus_act - act0), 3);
        end else begin
            chk("no_bus", 64'(bus_act - act0), 0);
        end
        chk("resp_id", 64'(resp_id), 64'(id));
        chk("resp_err", 64'(resp_err), 64'(ee));
        if (ee != 2'b01) chk("resp_data", 64'(resp_data), 64'(ed));
        if (resp_ready) begin
            @(negedge Clk);
            chk("resp_drop", 64'(resp_valid), 0);
        end
    endtask

    initial begin
        int log0, n, rcount, cyc, pend, rr, g, eg;
        logic [15:0] sd;
        logic [1:0]  se;
        logic        sid;
        logic [7:0]  cop [2][4];
        logic [15:0] ca [2][4];
        logic [15:0] cb [2][4];
        int          nxt [2];
        logic [7:0]  optab [6];
        logic [15:0] ed;
        logic [1:0]  ee;
        logic [32:0] exq[$];
        logic [32:0] ex;

        // Reset state
        repeat (2) @(negedge Clk);
        chk_reset_vals("reset");
        nReset = 1'b1;
        @(negedge Clk);
        chk_reset_vals("idle");

        // Single add with bus sequence
        log0 = bus_log.size();
        run_one(0, 8'h10, 16'd3, 16'd4);
        chk("add_log_len", 64'(bus_log.size() - log0), 3);
        if (bus_log.size() - log0 >= 3) begin
            chk("add_loadA", 64'(bus_log[log0]),   64'({16'h5010, 1'b0, 1'b1, 16'd3}));
            chk("add_loadB", 64'(bus_log[log0+1]), 64'({16'h5110, 1'b0, 1'b1, 16'd4}));
            chk("add_exec",  64'(bus_log[log0+2]), 64'({16'h5210, 1'b1, 1'b0, 16'd0}));
        end

        // Error paths and following legal command
        run_one(0, 8'h13, 16'd9, 16'd0);
        run_one(1, 8'h20, 16'd1, 16'd2);
        run_one(1, 8'h12, 16'h0100, 16'h0100);

        // Contention: both requesters hold valid with 4 commands each
        do_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                cop[i][j] = 8'h10 + 8'($urandom_range(0, 3));
                ca[i][j]  = 16'($urandom);
                cb[i][j]  = 16'($urandom_range(1, 65535));
            end
            nxt[i] = 0;
            set_cmd(i, cop[i][0], ca[i][0], cb[i][0]);
        end
        req_valid = 2'b11;
        rcount = 0; cyc = 0; pend = -1; rr = 0;
        while (rcount < 8 && cyc < 400) begin
            @(negedge Clk);
            cyc++;
            if (pend >= 0) begin
                if (nxt[pend] < 4) set_cmd(pend, cop[pend][nxt[pend]], ca[pend][nxt[pend]], cb[pend][nxt[pend]]);
                else req_valid[pend] = 1'b0;
                pend = -1;
            end
            if (req_ready != 0) begin
                g  = req_ready[0] ? 0 : 1;
                eg = req_valid[rr] ? rr : 1 - rr;
                rr = (eg + 1) % 2;
                chk("rr_grant", 64'(g), 64'(eg));
                if (nxt[g] < 4) begin
                    ref_model(cop[g][nxt[g]], ca[g][nxt[g]], cb[g][nxt[g]], ed, ee);
                    exq.push_back({1'(g), ed, 16'(ee)});
                    nxt[g]++;
                end else begin
                    chk("extra_grant", 64'(nxt[g]), 3);
                end
                pend = g;
            end
            if (resp_valid) begin
                if (exq.size() > 0) begin
                    ex = exq.pop_front();
                    chk("cont_id", 64'(resp_id), 64'(ex[32]));
                    chk("cont_data", 64'(resp_data), 64'(ex[31:16]));
                    chk("cont_err", 64'(resp_err), 64'(ex[1:0]));
                end else begin
                    chk("cont_spurious", 64'(resp_valid), 0);
                end
                rcount++;
            end
        end
        chk("cont_done", 64'(rcount), 8);
        req_valid = '0;
        @(negedge Clk);

        // Backpressure: stall 10 clocks with another requester waiting
        resp_ready = 1'b0;
        run_one(0, 8'h11, 16'h1234, 16'h0034);
        set_cmd(1, 8'h10, 16'h0001, 16'h0002);
        req_valid[1] = 1'b1;
        sd = resp_data; se = resp_err; sid = resp_id;
        chk("bp_data_init", 64'(sd), 64'h1200);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("bp_valid", 64'(resp_valid), 1);
            chk("bp_stable", 64'({sid, sd, se}), 64'({resp_id, resp_data, resp_err}));
            chk("bp_no_grant", 64'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge Clk);
        chk("bp_one_handshake", 64'(resp_valid), 0);
        run_one(1, 8'h10, 16'h0001, 16'h0002);

        // Reset while in EXEC abandons the command
        set_cmd(0, 8'h12, 16'd7, 16'd6);
        req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 40) begin @(negedge Clk); n++; end
        chk("rst_grant", 64'(n < 40), 1);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_in_exec", 64'({address, nRead}), 64'({16'h5212, 1'b0}));
        nReset = 1'b0;
        @(negedge Clk);
        chk_reset_vals("rst_exec");
        nReset = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin @(negedge Clk); if (resp_valid) n++; end
        chk("rst_no_resp", 64'(n), 0);
        run_one(0, 8'h11, 16'd5, 16'd7);

        // Random mix, including illegal opcodes and zero divisors
        optab[0] = 8'h10; optab[1] = 8'h11; optab[2] = 8'h12;
        optab[3] = 8'h13; optab[4] = 8'h20; optab[5] = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            run_one(int'($urandom_range(0, 1)), optab[$urandom_range(0, 5)], 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
